// File: rtl/raster_stamp_unpacker_pkg.sv
// rtl/raster_stamp_unpacker_pkg.sv - shared stamp type, state encoding and sizing helper for the raster stamp unpacker
package raster_stamp_unpacker_pkg;

    typedef struct packed {
        logic [11:0] pos_x;
        logic [11:0] pos_y;
        logic [3:0]  mask;
        logic [3:0]  pid;
    } raster_stamp_t;

    localparam int RASTER_STAMP_BITS        = $bits(raster_stamp_t);
    localparam int RASTER_UNPACK_STATE_BITS = 2;

    typedef enum logic [RASTER_UNPACK_STATE_BITS-1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } unpack_state_e;

    // Lane index width; a single-lane bus still carries a 1-bit lane field.
    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_stamp_unpacker_ebuf.sv
// rtl/raster_stamp_unpacker_ebuf.sv - elastic input buffer (circular FIFO) ahead of the unpacker FSM
module raster_stamp_unpacker_ebuf #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic             push;
    logic             pop;

    // Ready is forced low while reset is held so no packet is taken during reset.
    assign in_ready  = reset && (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer and occupancy tracking; reset empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/raster_stamp_unpacker.sv
// rtl/raster_stamp_unpacker.sv - replays NUM_LANES-stamp bus packets one stamp per cycle; optional RASTER_UNPACK_PERF_EN counters
module raster_stamp_unpacker
    import raster_stamp_unpacker_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_BUF    = 2
`ifdef RASTER_UNPACK_PERF_EN
    , parameter int PERF_CTR_BITS = 44
`endif
    , localparam int LANE_BITS = lane_bits(NUM_LANES)
    , localparam int REQ_BITS  = NUM_LANES * RASTER_STAMP_BITS + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    // req_data = {stamp[NUM_LANES-1], ..., stamp[0], done}
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [REQ_BITS-1:0]          req_data,
    output logic                         stamp_valid,
    output logic [RASTER_STAMP_BITS-1:0] stamp_data,
    output logic [LANE_BITS-1:0]         stamp_lane,
    output logic                         stamp_last,
    input  logic                         stamp_ready,
    output logic                         done_out,
    input  logic                         done_clear
`ifdef RASTER_UNPACK_PERF_EN
    , output logic [PERF_CTR_BITS-1:0]   perf_stamps
    , output logic [PERF_CTR_BITS-1:0]   perf_stalls
`endif
);

    localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(NUM_LANES - 1);

    logic                buf_valid;
    logic                buf_ready;
    logic [REQ_BITS-1:0] buf_data;

    generate
        if (IN_BUF > 0) begin : g_buf
            raster_stamp_unpacker_ebuf #(
                .DATAW (REQ_BITS),
                .DEPTH (IN_BUF)
            ) u_ebuf (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (req_valid),
                .in_ready  (req_ready),
                .in_data   (req_data),
                .out_valid (buf_valid),
                .out_ready (buf_ready),
                .out_data  (buf_data)
            );
        end else begin : g_direct
            assign buf_valid = req_valid;
            assign buf_data  = req_data;
            assign req_ready = buf_ready && reset;
        end
    endgenerate

    unpack_state_e       state;
    unpack_state_e       next_state;
    logic [LANE_BITS-1:0] lane_cnt;
    raster_stamp_t       hold [NUM_LANES];
    logic                in_done;
    logic                at_last;
    logic                stamp_fire;
    logic                accept;

    assign in_done    = buf_data[0];
    assign at_last    = (lane_cnt == LANE_LAST);
    assign stamp_fire = stamp_valid && stamp_ready;
    assign accept     = buf_valid && buf_ready;
    assign stamp_data = hold[lane_cnt];
    assign stamp_lane = lane_cnt;
    assign stamp_last = stamp_valid && at_last;

    // Next state and handshake outputs; a new packet may chain in on the last stamp.
    always_comb begin
        next_state  = state;
        buf_ready   = 1'b0;
        stamp_valid = 1'b0;
        case (state)
            IDLE: begin
                buf_ready = 1'b1;
                if (accept) next_state = in_done ? DONE : DRAIN;
            end
            DRAIN: begin
                stamp_valid = 1'b1;
                if (stamp_ready && at_last) begin
                    buf_ready = 1'b1;
                    if (accept) next_state = in_done ? DONE : DRAIN;
                    else        next_state = IDLE;
                end
            end
            DONE: begin
                if (done_clear) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; done_out is high exactly while parked in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            done_out <= 1'b0;
        end else begin
            state    <= next_state;
            done_out <= (next_state == DONE);
        end
    end

    // Lane counter steps on each consumed stamp and wraps after the last lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt <= '0;
        end else if (stamp_fire) begin
            lane_cnt <= at_last ? '0 : lane_cnt + LANE_BITS'(1);
        end
    end

    // Holding register captures the stamps of data packets; done packets leave it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) hold[i] <= '0;
        end else if (accept && !in_done) begin
            for (int i = 0; i < NUM_LANES; i++)
                hold[i] <= buf_data[1 + i*RASTER_STAMP_BITS +: RASTER_STAMP_BITS];
        end
    end

`ifdef RASTER_UNPACK_PERF_EN
    // Delivered-stamp and consumer-stall counters, wrapping at full width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stamps <= '0;
            perf_stalls <= '0;
        end else begin
            if (stamp_fire)                 perf_stamps <= perf_stamps + PERF_CTR_BITS'(1);
            if (stamp_valid && !stamp_ready) perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
        end
    end
`endif

endmodule

// File: tb/tb_raster_stamp_unpacker.sv
// tb/tb_raster_stamp_unpacker.sv - scoreboard bench for raster_stamp_unpacker (4-lane buffered and 1-lane direct), RASTER_UNPACK_PERF_EN aware
module tb_raster_stamp_unpacker;
    import raster_stamp_unpacker_pkg::*;

    localparam int NL = 4;
    localparam int SW = RASTER_STAMP_BITS;
    localparam int RB = NL * SW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [RB-1:0] req_data = '0;
    logic          stamp_valid;
    logic [SW-1:0] stamp_data;
    logic [1:0]    stamp_lane;
    logic          stamp_last;
    logic          stamp_ready = 1'b0;
    logic          done_out;
    logic          done_clear = 1'b0;

    logic          b_req_valid = 1'b0;
    logic          b_req_ready;
    logic [SW:0]   b_req_data = '0;
    logic          b_stamp_valid;
    logic [SW-1:0] b_stamp_data;
    logic          b_stamp_lane;
    logic          b_stamp_last;
    logic          b_stamp_ready = 1'b0;
    logic          b_done_out;
    logic          b_done_clear = 1'b0;

`ifdef RASTER_UNPACK_PERF_EN
    logic [43:0] perf_stamps, perf_stalls, b_perf_stamps, b_perf_stalls;
`endif

    raster_stamp_unpacker #(.NUM_LANES(NL), .IN_BUF(2)) u_dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .stamp_valid(stamp_valid), .stamp_data(stamp_data), .stamp_lane(stamp_lane),
        .stamp_last(stamp_last), .stamp_ready(stamp_ready),
        .done_out(done_out), .done_clear(done_clear)
`ifdef RASTER_UNPACK_PERF_EN
        , .perf_stamps(perf_stamps), .perf_stalls(perf_stalls)
`endif
    );

    raster_stamp_unpacker #(.NUM_LANES(1), .IN_BUF(0)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
        .stamp_valid(b_stamp_valid), .stamp_data(b_stamp_data), .stamp_lane(b_stamp_lane),
        .stamp_last(b_stamp_last), .stamp_ready(b_stamp_ready),
        .done_out(b_done_out), .done_clear(b_done_clear)
`ifdef RASTER_UNPACK_PERF_EN
        , .perf_stamps(b_perf_stamps), .perf_stalls(b_perf_stalls)
`endif
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic          is_done;
        logic [SW-1:0] data;
        int            lane;
        logic          last;
    } exp_t;

    exp_t sb[$];

    // Reference model: a data packet yields its stamps in lane order, last flag on the top lane;
    // a done packet yields a single done marker and no stamps.
    task automatic send(input logic done);
        logic [SW-1:0] st [NL];
        logic ok;
        for (int i = 0; i < NL; i++) st[i] = $urandom;
        for (int i = 0; i < NL; i++) req_data[1 + i*SW +: SW] = st[i];
        req_data[0] = done;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                if (done) sb.push_back('{1'b1, '0, 0, 1'b0});
                else for (int i = 0; i < NL; i++) sb.push_back('{1'b0, st[i], i, (i == NL - 1)});
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty(input int lim);
        for (int c = 0; c < lim && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    exp_t          mon_e;
    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic [SW-1:0] prev_data;
    logic [1:0]    prev_lane;
    logic          prev_last;
    int            bench_stamps = 0;
    int            bench_stalls = 0;

    // Monitor: pops the scoreboard on every stamp handshake and on each rising done_out.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done = 1'b0;
            bench_stamps = 0;
            bench_stalls = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", stamp_valid, 1);
                chk("hold_data", stamp_data, prev_data);
                chk("hold_lane", stamp_lane, prev_lane);
                chk("hold_last", stamp_last, prev_last);
            end
            if (done_out && !prev_done) begin
                if (sb.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("done_order", mon_e.is_done, 1);
                end
            end
            if (done_out) chk("done_no_stamp", stamp_valid, 0);
            if (stamp_valid && stamp_ready) begin
                bench_stamps++;
                if (sb.size() == 0) chk("stamp_unexpected", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("stamp_kind", mon_e.is_done, 0);
                    chk("stamp_data", stamp_data, mon_e.data);
                    chk("stamp_lane", stamp_lane, mon_e.lane);
                    chk("stamp_last", stamp_last, mon_e.last);
                end
            end
            if (stamp_valid && !stamp_ready) bench_stalls++;
            prev_stall = stamp_valid && !stamp_ready;
            prev_data = stamp_data;
            prev_lane = stamp_lane;
            prev_last = stamp_last;
            prev_done = done_out;
        end
    end

    logic rnd = 1'b0;
    // Random consumer back-pressure and done acknowledges during the random phase.
    always @(posedge clk) begin
        if (rnd) begin
            #1;
            stamp_ready = ($urandom % 4) != 0;
            done_clear = ($urandom % 4) == 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [SW-1:0] bst [6];
    logic [SW-1:0] bd;
    int run;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stamp_valid", stamp_valid, 0);
        chk("rst_stamp_last", stamp_last, 0);
        chk("rst_done_out", done_out, 0);
        chk("rst_stamp_data", stamp_data, 0);
        chk("rst_stamp_lane", stamp_lane, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_b_req_ready", b_req_ready, 0);
        chk("rst_b_stamp_valid", b_stamp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single packet: one extra cycle through the buffer, then 4 consecutive stamps
        stamp_ready = 1'b1;
        send(1'b0);
        req_valid = 1'b0;
        chk("lat_not_yet", stamp_valid, 0);
        @(posedge clk); #1;
        for (int k = 0; k < NL; k++) begin
            chk("seq_valid", stamp_valid, 1);
            chk("seq_lane", stamp_lane, k);
            chk("seq_last", stamp_last, (k == NL - 1));
            @(posedge clk); #1;
        end
        chk("seq_end_valid", stamp_valid, 0);

        // back-to-back packets: 8 valid cycles without a bubble
        send(1'b0);
        send(1'b0);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !stamp_valid; c++) begin
            @(posedge clk); #1;
        end
        run = 0;
        while (stamp_valid && run < 20) begin
            run++;
            @(posedge clk); #1;
        end
        chk("b2b_run", run, 8);

        // three stall cycles on lane 2
        send(1'b0);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !(stamp_valid && stamp_lane == 2); c++) begin
            @(posedge clk); #1;
        end
        stamp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stall_lane", stamp_lane, 2);
        chk("stall_valid", stamp_valid, 1);
        stamp_ready = 1'b1;
`ifdef RASTER_UNPACK_PERF_EN
        chk("perf_stalls_3", perf_stalls, 3);
`endif
        wait_empty(20);

        // done packet blocks further data until acknowledged
        send(1'b1);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !done_out; c++) begin
            @(posedge clk); #1;
        end
        chk("done_set", done_out, 1);
        chk("done_no_valid", stamp_valid, 0);
        send(1'b0);
        send(1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("done_buf_full", req_ready, 0);
        chk("done_held", done_out, 1);
        @(posedge clk); #1;
        done_clear = 1'b1;
        @(posedge clk); #1;
        done_clear = 1'b0;
        chk("done_cleared", done_out, 0);
        wait_empty(40);

        // single-lane direct instance: one packet per cycle, every stamp last
        b_stamp_ready = 1'b1;
        for (int k = 0; k < 6; k++) bst[k] = $urandom;
        for (int k = 0; k < 6; k++) begin
            b_req_data = {bst[k], 1'b0};
            b_req_valid = 1'b1;
            @(negedge clk);
            chk("b_req_ready", b_req_ready, 1);
            if (k > 0) begin
                chk("b_valid", b_stamp_valid, 1);
                chk("b_data", b_stamp_data, bst[k-1]);
                chk("b_last", b_stamp_last, 1);
            end
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("b_data_final", b_stamp_data, bst[5]);
        chk("b_last_final", b_stamp_last, 1);
        chk("b_lane_final", b_stamp_lane, 0);
        @(posedge clk); #1;

        // single-lane done: data offered but refused until done_clear
        bd = $urandom;
        b_req_data = {bd, 1'b1};
        b_req_valid = 1'b1;
        @(negedge clk);
        chk("b_done_ready", b_req_ready, 1);
        @(posedge clk); #1;
        b_req_data = {bd, 1'b0};
        @(negedge clk);
        chk("b_done_out", b_done_out, 1);
        chk("b_done_refuse", b_req_ready, 0);
        chk("b_done_novalid", b_stamp_valid, 0);
        @(posedge clk); #1;
        b_done_clear = 1'b1;
        @(negedge clk);
        chk("b_done_refuse2", b_req_ready, 0);
        @(posedge clk); #1;
        b_done_clear = 1'b0;
        @(negedge clk);
        chk("b_done_clr", b_done_out, 0);
        chk("b_accept_after", b_req_ready, 1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("b_after_valid", b_stamp_valid, 1);
        chk("b_after_data", b_stamp_data, bd);
        @(posedge clk); #1;

        // reset asserted mid-drain at lane 1
        send(1'b0);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !(stamp_valid && stamp_lane == 1); c++) begin
            @(posedge clk); #1;
        end
        stamp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", stamp_valid, 0);
        chk("mid_rst_last", stamp_last, 0);
        chk("mid_rst_ready", req_ready, 0);
        sb.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_lane", stamp_lane, 0);
        chk("post_rst_valid", stamp_valid, 0);
        chk("post_rst_done", done_out, 0);
`ifdef RASTER_UNPACK_PERF_EN
        chk("post_rst_perf", perf_stamps, 0);
`endif

        // randomized traffic with back-pressure and done packets
        rnd = 1'b1;
        for (int p = 0; p < 80; p++) begin
            send(($urandom % 6) == 0);
            if ($urandom % 2) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        req_valid = 1'b0;
        rnd = 1'b0;
        @(posedge clk); #2;
        stamp_ready = 1'b1;
        done_clear = 1'b1;
        wait_empty(600);
        done_clear = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
`ifdef RASTER_UNPACK_PERF_EN
        chk("perf_stamps", perf_stamps, bench_stamps);
        chk("perf_stalls", perf_stalls, bench_stalls);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
